nes_controller_responder: RTL and testbench
===========================================

# nes_controller_responder

Controller-side responder for the NES serial pad protocol: emulates the 4021 shift register inside a standard NES pad. It samples the host's latch and clock pins, captures eight button states on latch, and shifts them out active-low on the data pin, one bit per host clock rising edge. It serves as an on-chip loopback target for the host-side controller reader, and as a pad emulator driven by board switches.

## Interface
- SYNC_STAGES, default 2: synchronizer depth on nes_latch and nes_clk; legal values are 2 to 4.
- clk, input, 1: system clock, rising-edge.
- reset_n, input, 1: reset, synchronous, active-low.
- buttons, input, 8: button states, 1 = pressed, on-chip synchronous. Bit order is [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- nes_latch, input, 1: host latch pin, asynchronous to clk, active-high.
- nes_clk, input, 1: host pulse pin, asynchronous to clk; a shift occurs on its rising edge.
- nes_data, output, 1: serial data pin, 0 = pressed, registered.
- bit_count, output, 4: shifts completed since the last load, 0..8.
- frame_done, output, 1: one-cycle pulse on the 8th shift.

## Operation
- Synchronization:
  - nes_latch and nes_clk each pass through a SYNC_STAGES flop chain, giving latch_s and pclk_s.
  - One extra flop per signal holds the previous value for edge detection.
  - pclk_rise = pclk_s & ~pclk_q.
- State machine:
  - IDLE: entered after reset; nes_data = 1, bit_count = 0.
  - LOAD: held while latch_s = 1.
  - SHIFT: latch_s = 0 and bit_count < 8.
  - EMPTY: bit_count = 8.
- Transitions:
  - Any state to LOAD when latch_s = 1. This has highest priority and applies mid-frame too, re-arming the frame.
  - LOAD to SHIFT when latch_s = 0.
  - SHIFT to SHIFT on pclk_rise while bit_count < 7.
  - SHIFT to EMPTY on the pclk_rise that makes bit_count 8.
  - EMPTY stays in EMPTY until the next latch.
  - IDLE ignores pclk_rise.
- LOAD behaviour:
  - The 8-bit register sreg is parallel-loaded every cycle with ~buttons, so the last cycle of latch high wins.
  - bit_count is set to 0.
  - nes_data is set to ~buttons[0].
  - pclk_rise is ignored while in LOAD.
- SHIFT behaviour: on pclk_rise, sreg is shifted right with 0 entering bit 7, bit_count increments, and nes_data takes the new sreg[0].
- End of frame:
  - After 8 shifts, nes_data is 0 and stays 0 for every further pclk_rise until the next latch. This matches the stock pad, whose host reads 1 after eight bits.
  - bit_count saturates at 8.
- frame_done is high for exactly one clk on the cycle bit_count goes 7→8. It is never asserted in LOAD or EMPTY.
- buttons changes while in SHIFT have no effect on the frame in progress.
- nes_latch or nes_clk pulses shorter than one clk period may be missed. Hosts must hold each level for at least SYNC_STAGES+1 clk cycles.

## Timing
- Reset values: nes_data = 1, bit_count = 0, frame_done = 0, sreg = 8'hFF, state = IDLE, all synchronizer flops = 0.
- Latch latency: a nes_latch rising at the pin changes nes_data to ~buttons[0] SYNC_STAGES+1 clk edges later (3 with default SYNC_STAGES).
- Shift latency: a nes_clk rising at the pin updates nes_data SYNC_STAGES+1 clk edges later. frame_done and bit_count update on the same edge as nes_data.
- Simultaneous latch_s = 1 and pclk_rise in the same cycle: the load wins and no shift occurs.
- Reset asserted mid-frame returns all outputs to reset values on the next edge. The frame is not resumed; a new latch is required.
- nes_clk falling edges have no effect in any state.

## Test plan
- Reset and idle:
  - Hold reset_n = 0 for 4 cycles with nes_latch = nes_clk = 1. Required: nes_data = 1, bit_count = 0, frame_done = 0.
  - Release reset_n, then drive nes_clk pulses without any latch. Required: outputs unchanged.
- Full frame:
  - Set buttons = 8'b1010_0101 and pulse latch high for 12 cycles. Then drive 8 nes_clk pulses of 6 cycles high and 6 low.
  - Required nes_data sequence: 0,1,0,1,1,0,1,0.
  - Required: frame_done pulses once, 3 cycles after the 8th rising edge; bit_count = 8.
- Over-read: continue with 4 extra nes_clk pulses after the full frame. Required: nes_data = 0, bit_count stays 8, no further frame_done.
- Mid-frame re-latch:
  - After 3 shifts, change buttons to 8'h01 and raise latch.
  - Required: nes_data = 0 (A pressed), bit_count = 0.
  - Required: the next pulses give 1,1,1,1,1,1,1 for B..Right.
- Latch-dominance:
  - Hold latch high while toggling nes_clk, with buttons = 8'h02.
  - Required: nes_data stays 1 (A not pressed) and bit_count stays 0.
  - Then drop latch and pulse once. Required: nes_data = 0 (B pressed).
- Latency check with SYNC_STAGES = 3: measure cycles from nes_clk pin rise to the nes_data change. Required: exactly 4 clk edges.

Source files
------------

// File: rtl/nes_controller_responder.sv
// nes_controller_responder
//   Pad-side emulation of the 4021 shift register in a stock NES controller.
//   The host's latch and clock pins are synchronized into the clk domain.
//   While latch is high, the button states are parallel-loaded. After latch
//   drops, one bit is shifted out on each host clock rising edge.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   buttons     [7:0] 1 = pressed; [0]=A [1]=B [2]=Sel [3]=Start [4]=Up
//               [5]=Down [6]=Left [7]=Right
//   nes_latch   host latch pin (async to clk), active high
//   nes_clk     host pulse pin (async to clk), shifts on its rising edge
//   nes_data    serial data, 0 = pressed, registered
//   bit_count   [3:0] shifts completed since the last load, saturates at 8
//   frame_done  one-clk pulse on the eighth shift
//
// SYNC_STAGES must be 2..4. The host must hold each pin level for at least
// SYNC_STAGES+1 clk cycles, otherwise pulses may be lost.
module nes_controller_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] buttons,
  input  logic       nes_latch,
  input  logic       nes_clk,
  output logic       nes_data,
  output logic [3:0] bit_count,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, EMPTY} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] latch_sync, pclk_sync;
  logic                   latch_s, pclk_s, pclk_q, pclk_rise;

  logic [7:0] sreg, sreg_n;
  logic [3:0] cnt_n;
  logic       data_n, done_n;

  assign latch_s   = latch_sync[SYNC_STAGES-1];
  assign pclk_s    = pclk_sync[SYNC_STAGES-1];
  assign pclk_rise = pclk_s & ~pclk_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      latch_sync <= '0;
      pclk_sync  <= '0;
      pclk_q     <= 1'b0;
      state      <= IDLE;
      sreg       <= 8'hFF;
      bit_count  <= 4'd0;
      nes_data   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], nes_latch};
      pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], nes_clk};
      pclk_q     <= pclk_s;
      state      <= state_n;
      sreg       <= sreg_n;
      bit_count  <= cnt_n;
      nes_data   <= data_n;
      frame_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = bit_count;
    data_n  = nes_data;
    done_n  = 1'b0;
    // A synchronized latch always wins, even over a simultaneous clock edge.
    // The load is repeated every cycle, so the last latched cycle decides.
    if (latch_s) begin
      state_n = LOAD;
      sreg_n  = ~buttons;
      cnt_n   = 4'd0;
      data_n  = ~buttons[0];
    end else begin
      unique case (state)
        IDLE:  ;
        LOAD:  state_n = SHIFT;
        SHIFT: if (pclk_rise) begin
          // Zeros are shifted in, so the line reads 0 (pressed) after the
          // eighth bit. This matches a stock pad.
          sreg_n = {1'b0, sreg[7:1]};
          cnt_n  = 4'(bit_count + 4'd1);
          data_n = sreg[1];
          if (bit_count == 4'd7) begin
            state_n = EMPTY;
            done_n  = 1'b1;
          end
        end
        EMPTY: if (pclk_rise) data_n = 1'b0;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_controller_responder.sv
module tb_nes_controller_responder;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] buttons;
  logic       nes_latch, nes_clk;
  logic       nes_data, frame_done;
  logic [3:0] bit_count;
  logic       nes_data3, frame_done3;
  logic [3:0] bit_count3;

  int n_chk = 0, n_pass = 0;
  int cyc_cnt = 0, done_cnt = 0, done_cyc = -1;

  nes_controller_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .buttons(buttons), .nes_latch(nes_latch),
    .nes_clk(nes_clk), .nes_data(nes_data), .bit_count(bit_count),
    .frame_done(frame_done));

  nes_controller_responder #(.SYNC_STAGES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .buttons(buttons), .nes_latch(nes_latch),
    .nes_clk(nes_clk), .nes_data(nes_data3), .bit_count(bit_count3),
    .frame_done(frame_done3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;
  always @(negedge clk) if (frame_done) begin done_cnt++; done_cyc = cyc_cnt; end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    nes_clk = 1'b1; cyc(6);
    nes_clk = 1'b0; cyc(6);
  endtask

  task automatic do_latch(input logic [7:0] b);
    buttons = b; nes_latch = 1'b1; cyc(12);
    nes_latch = 1'b0; cyc(6);
  endtask

  logic [7:0] exp_seq;
  int rise8, d0, lat2, lat3;

  initial begin
    reset_n = 1'b0; nes_latch = 1'b1; nes_clk = 1'b1; buttons = 8'h00;
    cyc(4);
    chk("rst_data", nes_data, 1);
    chk("rst_cnt", bit_count, 0);
    chk("rst_done", frame_done, 0);

    // Host clocks with no latch: IDLE must ignore them.
    nes_latch = 1'b0; reset_n = 1'b1; cyc(6);
    nes_clk = 1'b0; cyc(6);
    pulse(); pulse();
    chk("idle_data", nes_data, 1);
    chk("idle_cnt", bit_count, 0);
    chk("idle_done", done_cnt, 0);

    // Full frame: 8'b1010_0101 read out active-low, A first.
    exp_seq = 8'b0101_1010;  // bit k = expected nes_data after k shifts
    do_latch(8'b1010_0101);
    chk("ff_load_data", nes_data, exp_seq[0]);
    chk("ff_load_cnt", bit_count, 0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) rise8 = cyc_cnt;
      pulse();
      chk($sformatf("ff_data%0d", k), nes_data, (k == 8) ? 0 : int'(exp_seq[k]));
      chk($sformatf("ff_cnt%0d", k), bit_count, k);
    end
    chk("ff_done_cnt", done_cnt, 1);
    chk("ff_done_lat", done_cyc - rise8, 3);

    // Over-read: data stays 0, count saturates, no extra frame_done.
    for (int k = 0; k < 4; k++) begin
      pulse();
      chk($sformatf("or_data%0d", k), nes_data, 0);
      chk($sformatf("or_cnt%0d", k), bit_count, 8);
    end
    chk("or_done_cnt", done_cnt, 1);

    // Re-latch in the middle of a frame.
    do_latch(8'b1010_0101);
    pulse(); pulse(); pulse();
    chk("ml_cnt3", bit_count, 3);
    buttons = 8'h01; nes_latch = 1'b1; cyc(6);
    chk("ml_data", nes_data, 0);
    chk("ml_cnt", bit_count, 0);
    nes_latch = 1'b0; cyc(6);
    for (int k = 1; k <= 7; k++) begin
      pulse();
      chk($sformatf("ml_bit%0d", k), nes_data, 1);
    end
    chk("ml_done_cnt", done_cnt, 1);

    // Latch held high: clock pulses must not shift.
    buttons = 8'h02; nes_latch = 1'b1; cyc(6);
    for (int k = 0; k < 3; k++) begin
      pulse();
      chk($sformatf("ld_data%0d", k), nes_data, 1);
      chk($sformatf("ld_cnt%0d", k), bit_count, 0);
    end
    nes_latch = 1'b0; cyc(6);
    pulse();
    chk("ld_b_data", nes_data, 0);
    chk("ld_b_cnt", bit_count, 1);

    // Mid-frame reset returns outputs to reset values.
    reset_n = 1'b0; cyc(1);
    chk("mr_data", nes_data, 1);
    chk("mr_cnt", bit_count, 0);
    reset_n = 1'b1; cyc(2);

    // Shift latency is SYNC_STAGES+1 edges from the pin rise.
    do_latch(8'h01);
    chk("lat_pre2", nes_data, 0);
    chk("lat_pre3", nes_data3, 0);
    lat2 = -1; lat3 = -1;
    nes_clk = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (lat2 < 0 && nes_data  == 1'b1) lat2 = i;
      if (lat3 < 0 && nes_data3 == 1'b1) lat3 = i;
    end
    nes_clk = 1'b0; cyc(6);
    chk("lat_ss2", lat2, 3);
    chk("lat_ss3", lat3, 4);
    chk("lat_cnt3", bit_count3, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", cyc_cnt, 0);
    $fatal(1, "timeout");
  end
endmodule
